dac_iq_stream_feeder: RTL and testbench

- Upstream feeder for the dual-channel interleaved DAC output stage.
- Accepts 32-bit AXI-Stream sample pairs: ch1 in [15:0], ch2 in [31:16], both signed two's complement.
- Buffers them in a small FIFO, then rounds, saturates and converts each half to INT_DAC_DATA_WIDTH-bit offset binary.
- Presents one ch1/ch2 pair per in_clk_data cycle. Also sequences the DAC IQ reset after start-up so channel routing is synchronised.

---
 rtl/dac_iq_stream_feeder.sv | 166 ++++++++++++++++
 tb/tb_dac_iq_stream_feeder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dac_iq_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module   : dac_iq_stream_feeder
// Brief    : AXIS IQ-pair FIFO feeder with round/saturate to offset-binary
//            DAC codes and DAC IQ-reset sequencing. Optional underflow
//            counter enabled by macro DAC_UNDERFLOW_COUNT_EN.
// Revision : 1.0
// ============================================================================
module dac_iq_stream_feeder #(
  parameter int INT_DAC_DATA_WIDTH  = 10,
  parameter int INT_AXIS_DATA_WIDTH = 32,
  parameter int INT_FIFO_DEPTH      = 8,
  parameter int INT_IQRST_CYCLES    = 4
) (
  input  logic                              in_clk_data,
  input  logic                              in_rstn,
  input  logic [INT_AXIS_DATA_WIDTH-1:0]    in_axis_tdata,
  input  logic                              in_axis_tvalid,
  output logic                              out_axis_tready,
  input  logic                              in_enable,
  input  logic                              in_dac_ready,
  output logic [INT_DAC_DATA_WIDTH-1:0]     out_dac_data_ch1,
  output logic [INT_DAC_DATA_WIDTH-1:0]     out_dac_data_ch2,
  output logic                              out_valid_ch1,
  output logic                              out_valid_ch2,
  output logic                              out_dac_rst,
  output logic                              out_underflow,
  output logic [$clog2(INT_FIFO_DEPTH):0]   out_fifo_level
`ifdef DAC_UNDERFLOW_COUNT_EN
  ,
  output logic [15:0]                       out_underflow_count
`endif
);

  localparam int W  = INT_DAC_DATA_WIDTH;
  localparam int AW = $clog2(INT_FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (INT_IQRST_CYCLES > 1) ? $clog2(INT_IQRST_CYCLES) : 1;

  localparam logic [W-1:0]  C_MID      = {1'b1, {(W-1){1'b0}}};
  localparam logic [LW-1:0] C_FULL     = LW'(INT_FIFO_DEPTH);
  localparam logic [LW-1:0] C_HALF     = LW'(INT_FIFO_DEPTH / 2);
  localparam logic [CW-1:0] C_RST_LAST = CW'(INT_IQRST_CYCLES - 1);

  typedef enum logic [1:0] {ST_RST, ST_IDLE, ST_PRIME, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [2*W-1:0]    mem_q [INT_FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic [2*W-1:0]    data_q;
  logic              valid_q;
  logic              underflow_q;

  logic [1:0][W-1:0] w_conv;
  logic              w_full, w_empty, w_active, w_flush;
  logic              w_push, w_pop, w_underflow;

  // Converted codes are what the FIFO stores, so the read side is a plain register.
  for (genvar h = 0; h < 2; h++) begin : g_half
    logic [15:0] s;
    assign s = in_axis_tdata[16*h +: 16];
    if (W == 16) begin : g_passthru
      assign w_conv[h] = {~s[15], s[14:0]};
    end else begin : g_round
      localparam logic [16:0] C_RND = 17'(1) << (15 - W);
      logic [16:0] r;
      logic [W-1:0] sat;
      logic unused_rnd;
      assign r          = {s[15], s} + C_RND;
      assign sat        = (!r[16] && r[15]) ? {1'b0, {(W-1){1'b1}}} : r[15:16-W];
      assign unused_rnd = ^r[15-W:0];
      assign w_conv[h]  = {~sat[W-1], sat[W-2:0]};
    end
  end

  assign w_full      = (level_q == C_FULL);
  assign w_empty     = (level_q == '0);
  assign w_active    = (state_q == ST_PRIME) || (state_q == ST_RUN);
  assign w_flush     = (state_q == ST_IDLE) || ((state_q != ST_RST) && !in_enable);
  assign w_push      = in_axis_tvalid && out_axis_tready && !w_flush;
  assign w_pop       = (state_q == ST_RUN) && in_enable && in_dac_ready && !w_empty;
  assign w_underflow = (state_q == ST_RUN) && in_enable && in_dac_ready && w_empty;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    case (state_q)
      ST_RST: begin
        if (rst_cnt_q == C_RST_LAST) state_d = ST_IDLE;
        else                         rst_cnt_d = rst_cnt_q + 1'b1;
      end
      ST_IDLE:  if (in_enable) state_d = ST_PRIME;
      ST_PRIME: begin
        if (!in_enable)             state_d = ST_IDLE;
        else if (level_q >= C_HALF) state_d = ST_RUN;
      end
      ST_RUN:   if (!in_enable) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk_data or negedge in_rstn) begin
    if (!in_rstn) begin
      state_q     <= ST_RST;
      rst_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      data_q      <= {C_MID, C_MID};
      valid_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      underflow_q <= w_underflow;
      if (w_flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
        data_q   <= {C_MID, C_MID};
        valid_q  <= 1'b0;
      end else begin
        if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (w_pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          data_q   <= mem_q[rd_ptr_q];
        end
        level_q <= level_q + LW'(w_push) - LW'(w_pop);
        valid_q <= w_pop;
      end
    end
  end

  always_ff @(posedge in_clk_data) begin
    if (w_push) mem_q[wr_ptr_q] <= w_conv;
  end

`ifdef DAC_UNDERFLOW_COUNT_EN
  logic [15:0] uf_cnt_q;

  always_ff @(posedge in_clk_data or negedge in_rstn) begin
    if (!in_rstn) begin
      uf_cnt_q <= '0;
    end else if ((state_q == ST_IDLE) && (state_d == ST_PRIME)) begin
      uf_cnt_q <= '0;
    end else if (w_underflow && (uf_cnt_q != 16'hFFFF)) begin
      uf_cnt_q <= uf_cnt_q + 16'd1;
    end
  end

  assign out_underflow_count = uf_cnt_q;
`endif

  assign out_axis_tready  = w_active && !w_full;
  assign out_dac_rst      = (state_q == ST_RST);
  assign out_dac_data_ch1 = data_q[W-1:0];
  assign out_dac_data_ch2 = data_q[2*W-1:W];
  assign out_valid_ch1    = valid_q;
  assign out_valid_ch2    = valid_q;
  assign out_underflow    = underflow_q;
  assign out_fifo_level   = level_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_iq_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_iq_stream_feeder
// Brief    : Directed self-checking bench for dac_iq_stream_feeder (W=10, depth 8).
// Revision : 1.0
// ============================================================================
module tb_dac_iq_stream_feeder;

  localparam int W  = 10;
  localparam int D  = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [31:0]   tdata;
  logic          tvalid;
  logic          tready;
  logic          enable;
  logic          dac_ready;
  logic [W-1:0]  ch1, ch2;
  logic          vld1, vld2;
  logic          dac_rst;
  logic          underflow;
  logic [LW-1:0] level;
`ifdef DAC_UNDERFLOW_COUNT_EN
  logic [15:0]   uf_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int acc;

  always #5 clk = ~clk;

  dac_iq_stream_feeder #(
    .INT_DAC_DATA_WIDTH (W),
    .INT_AXIS_DATA_WIDTH(32),
    .INT_FIFO_DEPTH     (D),
    .INT_IQRST_CYCLES   (4)
  ) u_dut (
    .in_clk_data        (clk),
    .in_rstn            (rstn),
    .in_axis_tdata      (tdata),
    .in_axis_tvalid     (tvalid),
    .out_axis_tready    (tready),
    .in_enable          (enable),
    .in_dac_ready       (dac_ready),
    .out_dac_data_ch1   (ch1),
    .out_dac_data_ch2   (ch2),
    .out_valid_ch1      (vld1),
    .out_valid_ch2      (vld2),
    .out_dac_rst        (dac_rst),
    .out_underflow      (underflow),
    .out_fifo_level     (level)
`ifdef DAC_UNDERFLOW_COUNT_EN
    ,
    .out_underflow_count(uf_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] e1, input logic [31:0] e2);
    check({tag, "_vld1"}, 32'(vld1), 32'(v));
    check({tag, "_vld2"}, 32'(vld2), 32'(v));
    check({tag, "_ch1"}, 32'(ch1), e1);
    check({tag, "_ch2"}, 32'(ch2), e2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ch1 = k*64, ch2 = -k*64: codes are exactly midscale +k and -k.
  function automatic logic [31:0] ramp(input int k);
    logic [15:0] p, n;
    p = 16'(k * 64);
    n = 16'(-(k * 64));
    return {n, p};
  endfunction

  task automatic send(input logic [31:0] d);
    int n;
    tdata  = d;
    tvalid = 1'b1;
    n = 0;
    while (!tready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("tready_timeout", 32'(tready), 32'd1);
    else         tick();
    tvalid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; tdata = '0; tvalid = 1'b0; enable = 1'b0; dac_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dac_rst", 32'(dac_rst), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_tready", 32'(tready), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check_out("rst", 1'b0, 32'h200, 32'h200);
`ifdef DAC_UNDERFLOW_COUNT_EN
    check("rst_uf_count", 32'(uf_count), 32'd0);
`endif

    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("iqrst_high", 32'(dac_rst), 32'd1);
      tick();
    end
    check("iqrst_low", 32'(dac_rst), 32'd0);
    tick(); tick();
    check_out("idle", 1'b0, 32'h200, 32'h200);
    check("idle_tready", 32'(tready), 32'd0);

    // Priming and conversion
    dac_ready = 1'b1;
    enable    = 1'b1;
    tick();
    check("prime_tready", 32'(tready), 32'd1);
    send(32'h8000_7FFF);
    send(32'h0020_001F);
    send(32'h1234_5678);
    check("prime3_vld", 32'(vld1), 32'd0);
    check("prime3_level", 32'(level), 32'd3);
    send(32'hFFC0_0040);
    check("prime4_vld", 32'(vld1), 32'd0);
    check("prime4_level", 32'(level), 32'd4);
    tick();
    check("run_entry_vld", 32'(vld1), 32'd0);
    tick(); check_out("pair0", 1'b1, 32'h3FF, 32'h000);
    tick(); check_out("pair1", 1'b1, 32'h200, 32'h201);
    tick(); check_out("pair2", 1'b1, 32'h35A, 32'h249);
    tick(); check_out("pair3", 1'b1, 32'h201, 32'h1FF);
    check("pair3_uf", 32'(underflow), 32'd0);

    // Underflow: five starved cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("starve", 1'b0, 32'h201, 32'h1FF);
      check("starve_uf", 32'(underflow), 32'd1);
    end
    dac_ready = 1'b0;
    tick();
    check("starve_end_uf", 32'(underflow), 32'd0);
`ifdef DAC_UNDERFLOW_COUNT_EN
    check("uf_count5", 32'(uf_count), 32'd5);
`endif

    // Backpressure: 10 beats offered while the DAC is stalled
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      tdata  = ramp(i + 1);
      tvalid = 1'b1;
      if (tready) acc++;
      tick();
    end
    tvalid = 1'b0;
    check("bp_accepted", 32'(acc), 32'd8);
    check("bp_tready", 32'(tready), 32'd0);
    check("bp_level", 32'(level), 32'd8);
    check("bp_vld", 32'(vld1), 32'd0);
    check("bp_uf", 32'(underflow), 32'd0);
    dac_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_out("drain", 1'b1, 32'(32'h200 + k + 1), 32'(32'h200 - (k + 1)));
    end
    tick();
    check_out("drained", 1'b0, 32'h208, 32'h1F8);
    check("drained_uf", 32'(underflow), 32'd1);
    dac_ready = 1'b0;
    tick();

    // Disable mid-stream with five entries queued
    for (int i = 0; i < 5; i++) send(ramp(i + 11));
    check("dis_level5", 32'(level), 32'd5);
    tdata  = ramp(30);
    tvalid = 1'b1;
    enable = 1'b0;
    tick();
    tvalid = 1'b0;
    check("dis_level", 32'(level), 32'd0);
    check("dis_tready", 32'(tready), 32'd0);
    check_out("dis", 1'b0, 32'h200, 32'h200);
    tick();
    check("dis_level_hold", 32'(level), 32'd0);

    // Re-enable needs a fresh prime
    dac_ready = 1'b1;
    enable    = 1'b1;
    tick();
    check("reprime_tready", 32'(tready), 32'd1);
`ifdef DAC_UNDERFLOW_COUNT_EN
    check("reprime_uf_count", 32'(uf_count), 32'd0);
`endif
    send(ramp(1));
    send(ramp(2));
    send(ramp(3));
    check("reprime3_vld", 32'(vld1), 32'd0);
    check("reprime3_level", 32'(level), 32'd3);
    send(ramp(4));
    tick();
    tick();
    check_out("reprime0", 1'b1, 32'h201, 32'h1FF);
    tick();
    check_out("reprime1", 1'b1, 32'h202, 32'h1FE);

    // Asynchronous reset mid-cycle
    #2;
    rstn = 1'b0;
    #1;
    check("arst_dac_rst", 32'(dac_rst), 32'd1);
    check("arst_level", 32'(level), 32'd0);
    check("arst_tready", 32'(tready), 32'd0);
    check_out("arst", 1'b0, 32'h200, 32'h200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
